// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single-request load/store sequencer for the 256x16 data RAM.
// It handles full-word reads and writes, and does a read-modify-write for byte-masked writes.
module ram_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, merge_q, rdata_q, merged;
    logic [1:0] be_q;
    logic wr_q, accept;
    assign accept = req_valid && state == IDLE;
    // Enabled lanes come from the request, the rest from the word just read back.
    assign merged = {be_q[1] ? wdata_q[DATA_W-1:DATA_W/2] : ram_dout[DATA_W-1:DATA_W/2],
                     be_q[0] ? wdata_q[DATA_W/2-1:0] : ram_dout[DATA_W/2-1:0]};
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = !req_valid ? IDLE : !req_wr ? RD_ADDR :
                                req_be == 2'b11 ? WR : req_be == 2'b00 ? DONE : RD_ADDR;
            RD_ADDR: state_nx = RD_DATA;
            RD_DATA: state_nx = wr_q ? WR : DONE;
            WR:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                wr_q    <= req_wr;
                if (req_wr) merge_q <= req_wdata;
            end
            if (state == RD_DATA) begin
                if (wr_q) merge_q <= merged;
                else rdata_q <= ram_dout;
            end
        end
    end
    assign req_ready = state == IDLE;
    assign done      = state == DONE;
    assign ram_we    = state == WR;
    assign ram_addr  = addr_q;
    assign ram_din   = merge_q;
    assign rdata     = rdata_q;
endmodule
